udp_jpeg_pkt_sched: RTL and testbench

- Packet scheduler in front of the 128-bit UDP byte sender.
- Accepts one JPEG frame descriptor (DDR3 byte address plus length) and splits it into UDP packets of at most MAX_PAYLOAD bytes.
- For every packet it drives the sender's enable, length, last-packet flag, packet rank and IPv4 identification, and tracks the DDR3 read address.
- Inserts an inter-packet gap and aborts on sender timeout.

---
 rtl/udp_jpeg_pkt_sched.sv | 199 +++++++++++++++++++
 tb/tb_udp_jpeg_pkt_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_jpeg_pkt_sched.sv
// Splits one JPEG frame descriptor into UDP packets for the 128-bit byte sender,
// sequencing enable, length, rank, IPv4 id and DDR3 read address per packet.
module udp_jpeg_pkt_sched #(
    parameter int unsigned MAX_PAYLOAD    = 1024,
    parameter int unsigned GAP_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned ADDR_W         = 28
) (
    input  logic              i_udp_clk50m,
    input  logic              i_rst,
    input  logic              i_frame_valid,
    input  logic [ADDR_W-1:0] i_frame_addr,
    input  logic [23:0]       i_frame_len,
    output logic              o_frame_ready,
    input  logic              i_mac_init_ready,
    output logic              o_send_en,
    output logic [15:0]       o_jpeg_len,
    output logic              o_last_frame_flag,
    output logic [14:0]       o_pkt_rank,
    output logic [15:0]       o_ipv4_sign,
    input  logic              i_ddr3_data_upd_req,
    input  logic              i_send_frame_down,
    output logic [ADDR_W-1:0] o_ddr3_rd_addr,
    output logic              o_busy,
    output logic              o_err
);

    localparam int unsigned LEN_W  = 24;
    localparam int unsigned JLEN_W = 16;
    localparam int unsigned RANK_W = 15;
    localparam int unsigned ID_W   = 16;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 2);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_SEND,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic                frame_ready_q, frame_ready_d;
    logic                busy_q, busy_d;
    logic                send_en_q, send_en_d;
    logic [JLEN_W-1:0]   jpeg_len_q, jpeg_len_d;
    logic                last_q, last_d;
    logic [RANK_W-1:0]   pkt_rank_q, pkt_rank_d;
    logic [RANK_W-1:0]   rank_q, rank_d;
    logic [ID_W-1:0]     ipv4_sign_q, ipv4_sign_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   pkt_base_q, pkt_base_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic                err_q, err_d;
    logic                req_q, req_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                req_rise;

    assign req_rise = i_ddr3_data_upd_req & ~req_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        send_en_d   = send_en_q;
        jpeg_len_d  = jpeg_len_q;
        last_d      = last_q;
        pkt_rank_d  = pkt_rank_q;
        rank_d      = rank_q;
        ipv4_sign_d = ipv4_sign_q;
        rd_addr_d   = rd_addr_q;
        pkt_base_d  = pkt_base_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        req_d       = i_ddr3_data_upd_req;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Zero-length descriptors are consumed without producing a packet
                if (frame_ready_q && i_frame_valid && (i_frame_len != LEN_W'(0))) begin
                    pkt_base_d  = i_frame_addr;
                    remaining_d = i_frame_len;
                    rank_d      = RANK_W'(0);
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                jpeg_len_d = (remaining_q > LEN_W'(MAX_PAYLOAD)) ? JLEN_W'(MAX_PAYLOAD)
                                                                 : JLEN_W'(remaining_q);
                last_d     = (remaining_q <= LEN_W'(MAX_PAYLOAD));
                pkt_rank_d = rank_q;
                rd_addr_d  = pkt_base_q;
                state_d    = S_START;
            end
            S_START: begin
                if (i_mac_init_ready) begin
                    send_en_d = 1'b1;
                    tmo_cnt_d = TMO_W'(0);
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (req_rise) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(16);
                end
                // Done takes priority over a coincident timeout
                if (i_send_frame_down) begin
                    send_en_d   = 1'b0;
                    ipv4_sign_d = ipv4_sign_q + ID_W'(1);
                    remaining_d = remaining_q - LEN_W'(jpeg_len_q);
                    pkt_base_d  = pkt_base_q + ADDR_W'(MAX_PAYLOAD);
                    rank_d      = rank_q + RANK_W'(1);
                    gap_cnt_d   = GAP_W'(0);
                    if (last_q) begin
                        state_d = S_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if ((32'(tmo_cnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
                    send_en_d   = 1'b0;
                    err_d       = 1'b1;
                    ipv4_sign_d = ipv4_sign_q + ID_W'(1);
                    remaining_d = LEN_W'(0);
                    state_d     = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                if ((32'(gap_cnt_q) + 32'd1) >= 32'(GAP_CYCLES)) begin
                    state_d = S_LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                send_en_d = 1'b0;
            end
        endcase

        frame_ready_d = (state_d == S_IDLE) && i_mac_init_ready;
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge i_udp_clk50m) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            send_en_q     <= 1'b0;
            jpeg_len_q    <= '0;
            last_q        <= 1'b0;
            pkt_rank_q    <= '0;
            rank_q        <= '0;
            ipv4_sign_q   <= '0;
            rd_addr_q     <= '0;
            pkt_base_q    <= '0;
            remaining_q   <= '0;
            err_q         <= 1'b0;
            req_q         <= 1'b0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            frame_ready_q <= frame_ready_d;
            busy_q        <= busy_d;
            send_en_q     <= send_en_d;
            jpeg_len_q    <= jpeg_len_d;
            last_q        <= last_d;
            pkt_rank_q    <= pkt_rank_d;
            rank_q        <= rank_d;
            ipv4_sign_q   <= ipv4_sign_d;
            rd_addr_q     <= rd_addr_d;
            pkt_base_q    <= pkt_base_d;
            remaining_q   <= remaining_d;
            err_q         <= err_d;
            req_q         <= req_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign o_frame_ready     = frame_ready_q;
    assign o_busy            = busy_q;
    assign o_send_en         = send_en_q;
    assign o_jpeg_len        = jpeg_len_q;
    assign o_last_frame_flag = last_q;
    assign o_pkt_rank        = pkt_rank_q;
    assign o_ipv4_sign       = ipv4_sign_q;
    assign o_ddr3_rd_addr    = rd_addr_q;
    assign o_err             = err_q;

endmodule

// File: tb/tb_udp_jpeg_pkt_sched.sv
// Directed bench for udp_jpeg_pkt_sched: packet splitting, addressing, IPv4 id wrap,
// zero length, timeout abort (second instance), reset and MAC-ready stall.
module tb_udp_jpeg_pkt_sched;

    localparam int unsigned ADDR_W = 28;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic              rst, frame_valid, t_valid, mac_ready, upd_req, down, t_down;
    logic [ADDR_W-1:0] frame_addr;
    logic [23:0]       frame_len;

    logic              frame_ready, send_en, last, busy, err;
    logic [15:0]       jpeg_len, ipv4;
    logic [14:0]       pkt_rank;
    logic [ADDR_W-1:0] rd_addr;

    logic              t_frame_ready, t_send_en, t_last, t_busy, t_err;
    logic [15:0]       t_jpeg_len, t_ipv4;
    logic [14:0]       t_pkt_rank;
    logic [ADDR_W-1:0] t_rd_addr;

    int checks = 0;
    int errors = 0;

    logic              cap_ok, cap_last;
    logic [15:0]       cap_len, cap_id;
    logic [14:0]       cap_rank;
    logic [ADDR_W-1:0] cap_a0, cap_a1;

    udp_jpeg_pkt_sched #(.MAX_PAYLOAD(1024), .GAP_CYCLES(8), .TIMEOUT_CYCLES(1000), .ADDR_W(ADDR_W)) dut (
        .i_udp_clk50m(clk), .i_rst(rst), .i_frame_valid(frame_valid), .i_frame_addr(frame_addr),
        .i_frame_len(frame_len), .o_frame_ready(frame_ready), .i_mac_init_ready(mac_ready),
        .o_send_en(send_en), .o_jpeg_len(jpeg_len), .o_last_frame_flag(last), .o_pkt_rank(pkt_rank),
        .o_ipv4_sign(ipv4), .i_ddr3_data_upd_req(upd_req), .i_send_frame_down(down),
        .o_ddr3_rd_addr(rd_addr), .o_busy(busy), .o_err(err)
    );

    udp_jpeg_pkt_sched #(.MAX_PAYLOAD(1024), .GAP_CYCLES(8), .TIMEOUT_CYCLES(100), .ADDR_W(ADDR_W)) dut_t (
        .i_udp_clk50m(clk), .i_rst(rst), .i_frame_valid(t_valid), .i_frame_addr(frame_addr),
        .i_frame_len(frame_len), .o_frame_ready(t_frame_ready), .i_mac_init_ready(mac_ready),
        .o_send_en(t_send_en), .o_jpeg_len(t_jpeg_len), .o_last_frame_flag(t_last), .o_pkt_rank(t_pkt_rank),
        .o_ipv4_sign(t_ipv4), .i_ddr3_data_upd_req(upd_req), .i_send_frame_down(t_down),
        .o_ddr3_rd_addr(t_rd_addr), .o_busy(t_busy), .o_err(t_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one descriptor; returns at the negedge after the accepting edge
    task automatic send_frame(input bit which, input logic [ADDR_W-1:0] a, input logic [23:0] l, output bit ok);
        int n = 0;
        while (!(which ? t_frame_ready : frame_ready) && n < 50) begin
            tick();
            n++;
        end
        ok = which ? t_frame_ready : frame_ready;
        frame_addr = a;
        frame_len  = l;
        if (which) t_valid = 1'b1; else frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        t_valid     = 1'b0;
    endtask

    task automatic wait_send(input bit which, output bit ok);
        int n = 0;
        while (!(which ? t_send_en : send_en) && n < 100) begin
            tick();
            n++;
        end
        ok = which ? t_send_en : send_en;
    endtask

    // Service one packet on the main instance: capture fields, issue word requests, signal done
    task automatic run_pkt(input int pulses, input int hold);
        bit ok;
        wait_send(1'b0, ok);
        cap_ok   = ok;
        cap_len  = jpeg_len;
        cap_last = last;
        cap_rank = pkt_rank;
        cap_a0   = rd_addr;
        cap_id   = ipv4;
        for (int i = 0; i < pulses; i++) begin
            upd_req = 1'b1;
            repeat (hold) tick();
            upd_req = 1'b0;
            tick();
        end
        cap_a1 = rd_addr;
        down = 1'b1;
        tick();
        down = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_valid = 1'b0; t_valid = 1'b0; mac_ready = 1'b1;
        upd_req = 1'b0; down = 1'b0; t_down = 1'b0; frame_addr = '0; frame_len = '0;
        repeat (3) tick();
        checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL rst_send_en got %b exp 0", send_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (ipv4 !== 16'h0000) begin errors++; $display("FAIL rst_ipv4 got %h exp 0000", ipv4); end
        checks++; if (rd_addr !== 28'h0) begin errors++; $display("FAIL rst_rd_addr got %h exp 0", rd_addr); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rst_frame_ready got %b exp 0", frame_ready); end
        checks++; if ({err, t_err, t_send_en} !== 3'b000) begin errors++; $display("FAIL rst_err got %b exp 000", {err, t_err, t_send_en}); end
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got %b exp 1", frame_ready); end
    endtask

    task automatic test_three_packets();
        logic [15:0]       e_len  [3] = '{16'd1024, 16'd1024, 16'd452};
        logic              e_last [3] = '{1'b0, 1'b0, 1'b1};
        logic [ADDR_W-1:0] e_addr [3] = '{28'h1000, 28'h1400, 28'h1800};
        bit ok;
        send_frame(1'b0, 28'h1000, 24'd2500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tp_accept got %b exp 1", ok); end
        checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL tp_lat0 got %b exp 0", send_en); end
        tick();
        checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL tp_lat1 got %b exp 0", send_en); end
        tick();
        checks++; if (send_en !== 1'b1) begin errors++; $display("FAIL tp_lat2 got %b exp 1", send_en); end
        for (int p = 0; p < 3; p++) begin
            run_pkt(2, 3);
            checks++; if (cap_ok !== 1'b1) begin errors++; $display("FAIL tp%0d_send_en timeout", p); end
            checks++; if (cap_len !== e_len[p]) begin errors++; $display("FAIL tp%0d_len got %0d exp %0d", p, cap_len, e_len[p]); end
            checks++; if (cap_last !== e_last[p]) begin errors++; $display("FAIL tp%0d_last got %b exp %b", p, cap_last, e_last[p]); end
            checks++; if (cap_rank !== 15'(p)) begin errors++; $display("FAIL tp%0d_rank got %0d exp %0d", p, cap_rank, p); end
            checks++; if (cap_a0 !== e_addr[p]) begin errors++; $display("FAIL tp%0d_addr got %h exp %h", p, cap_a0, e_addr[p]); end
            checks++; if (cap_a1 !== e_addr[p] + 28'h20) begin errors++; $display("FAIL tp%0d_addr_end got %h exp %h", p, cap_a1, e_addr[p] + 28'h20); end
            checks++; if (cap_id !== 16'(p)) begin errors++; $display("FAIL tp%0d_ipv4 got %h exp %h", p, cap_id, 16'(p)); end
            checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL tp%0d_en_fall got %b exp 0", p, send_en); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tp_busy_end got %b exp 0", busy); end
        checks++; if (ipv4 !== 16'd3) begin errors++; $display("FAIL tp_ipv4_end got %h exp 0003", ipv4); end
    endtask

    task automatic test_single_1024();
        bit ok;
        send_frame(1'b0, 28'h20000, 24'd1024, ok);
        run_pkt(64, 1);
        checks++; if (cap_len !== 16'd1024) begin errors++; $display("FAIL s_len got %0d exp 1024", cap_len); end
        checks++; if (cap_last !== 1'b1) begin errors++; $display("FAIL s_last got %b exp 1", cap_last); end
        checks++; if (cap_rank !== 15'd0) begin errors++; $display("FAIL s_rank got %0d exp 0", cap_rank); end
        checks++; if (cap_a0 !== 28'h20000) begin errors++; $display("FAIL s_addr got %h exp 0020000", cap_a0); end
        checks++; if (cap_a1 !== 28'h20400) begin errors++; $display("FAIL s_addr_end got %h exp 0020400", cap_a1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s_busy got %b exp 0", busy); end
        checks++; if (ipv4 !== 16'd4) begin errors++; $display("FAIL s_ipv4 got %h exp 0004", ipv4); end
    endtask

    task automatic test_zero_len();
        bit ok;
        logic seen_en = 1'b0;
        logic seen_busy = 1'b0;
        send_frame(1'b0, 28'h30000, 24'd0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL z_accept got %b exp 1", ok); end
        repeat (20) begin
            seen_en   = seen_en | send_en;
            seen_busy = seen_busy | busy;
            tick();
        end
        checks++; if (seen_en !== 1'b0) begin errors++; $display("FAIL z_send_en got %b exp 0", seen_en); end
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL z_busy got %b exp 0", seen_busy); end
        checks++; if (ipv4 !== 16'd4) begin errors++; $display("FAIL z_ipv4 got %h exp 0004", ipv4); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL z_ready got %b exp 1", frame_ready); end
    endtask

    task automatic test_timeout();
        bit ok;
        logic bad = 1'b0;
        send_frame(1'b1, 28'h3000, 24'd2000, ok);
        wait_send(1'b1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_p0_en timeout"); end
        t_down = 1'b1;
        tick();
        t_down = 1'b0;
        wait_send(1'b1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_p1_en timeout"); end
        checks++; if (t_pkt_rank !== 15'd1) begin errors++; $display("FAIL to_p1_rank got %0d exp 1", t_pkt_rank); end
        checks++; if (t_jpeg_len !== 16'd976) begin errors++; $display("FAIL to_p1_len got %0d exp 976", t_jpeg_len); end
        repeat (99) begin
            tick();
            bad = bad | t_err | ~t_send_en;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", bad); end
        tick();
        checks++; if (t_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", t_err); end
        checks++; if (t_send_en !== 1'b0) begin errors++; $display("FAIL to_send_en got %b exp 0", t_send_en); end
        checks++; if (t_busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b exp 0", t_busy); end
        checks++; if (t_ipv4 !== 16'd2) begin errors++; $display("FAIL to_ipv4 got %h exp 0002", t_ipv4); end
        tick();
        checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b exp 0", t_err); end
        send_frame(1'b1, 28'h5000, 24'd100, ok);
        wait_send(1'b1, ok);
        checks++; if (t_pkt_rank !== 15'd0) begin errors++; $display("FAIL to_next_rank got %0d exp 0", t_pkt_rank); end
        checks++; if (t_jpeg_len !== 16'd100) begin errors++; $display("FAIL to_next_len got %0d exp 100", t_jpeg_len); end
        checks++; if (t_rd_addr !== 28'h5000) begin errors++; $display("FAIL to_next_addr got %h exp 0005000", t_rd_addr); end
        t_down = 1'b1;
        tick();
        t_down = 1'b0;
        checks++; if (t_ipv4 !== 16'd3) begin errors++; $display("FAIL to_next_ipv4 got %h exp 0003", t_ipv4); end
    endtask

    task automatic test_ipv4_wrap();
        bit ok;
        force dut.ipv4_sign_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.ipv4_sign_q;
        send_frame(1'b0, 28'h8000, 24'd1040, ok);
        run_pkt(1, 1);
        checks++; if (cap_id !== 16'hFFFF) begin errors++; $display("FAIL w_p0_ipv4 got %h exp ffff", cap_id); end
        checks++; if (cap_last !== 1'b0) begin errors++; $display("FAIL w_p0_last got %b exp 0", cap_last); end
        run_pkt(1, 1);
        checks++; if (cap_id !== 16'h0000) begin errors++; $display("FAIL w_p1_ipv4 got %h exp 0000", cap_id); end
        checks++; if (cap_len !== 16'd16) begin errors++; $display("FAIL w_p1_len got %0d exp 16", cap_len); end
        checks++; if (cap_a0 !== 28'h8400) begin errors++; $display("FAIL w_p1_addr got %h exp 0008400", cap_a0); end
        checks++; if ({cap_last, cap_rank} !== {1'b1, 15'd1}) begin errors++; $display("FAIL w_p1_last_rank got %b/%0d exp 1/1", cap_last, cap_rank); end
        checks++; if (ipv4 !== 16'h0001) begin errors++; $display("FAIL w_ipv4_end got %h exp 0001", ipv4); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_frame(1'b0, 28'hA000, 24'd500, ok);
        wait_send(1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rm_en timeout"); end
        rst = 1'b1;
        tick();
        checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL rm_send_en got %b exp 0", send_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
        checks++; if ({jpeg_len, pkt_rank, last} !== 32'h0) begin errors++; $display("FAIL rm_fields got %h exp 0", {jpeg_len, pkt_rank, last}); end
        checks++; if (ipv4 !== 16'h0000) begin errors++; $display("FAIL rm_ipv4 got %h exp 0000", ipv4); end
        checks++; if (rd_addr !== 28'h0) begin errors++; $display("FAIL rm_rd_addr got %h exp 0", rd_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mac_stall();
        bit ok;
        logic seen_en = 1'b0;
        send_frame(1'b0, 28'hB000, 24'd32, ok);
        mac_ready = 1'b0;
        tick();
        repeat (5) begin
            tick();
            seen_en = seen_en | send_en;
        end
        checks++; if (seen_en !== 1'b0) begin errors++; $display("FAIL ms_send_en got %b exp 0", seen_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ms_busy got %b exp 1", busy); end
        mac_ready = 1'b1;
        tick();
        checks++; if (send_en !== 1'b1) begin errors++; $display("FAIL ms_resume got %b exp 1", send_en); end
        checks++; if ({jpeg_len, last} !== {16'd32, 1'b1}) begin errors++; $display("FAIL ms_fields got %0d/%b exp 32/1", jpeg_len, last); end
        down = 1'b1;
        tick();
        down = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ms_busy_end got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_three_packets();
        test_single_1024();
        test_zero_len();
        test_timeout();
        test_ipv4_wrap();
        test_reset_mid();
        test_mac_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
